// File: rtl/frame_tx.sv
// frame_tx -- byte-serial frame transmitter feeding a Manchester encoder.
//
// A frame is a start-of-frame ETU (tx_data=1) followed by each payload
// byte LSB first, optionally with an odd-parity ETU after each byte.
// After the frame, a fixed idle gap is enforced before the next frame.
// A one-byte holding register decouples the byte source from the shifter.
//
// Configuration macro:
//   FRAME_TX_PARITY_EN  defined   -> odd-parity ETU after every byte (9 ETUs/byte)
//                       undefined -> no parity ETU (8 ETUs/byte)
//
// Parameters:
//   ETU_CLKS   clocks per ETU (bit period), 2..255
//   GAP_ETUS   idle ETUs after each frame, 1..15
//
// Ports:
//   clk         single clock, all logic on posedge
//   rst         asynchronous active-high reset
//   in_byte     payload byte, transmitted LSB first
//   in_valid    in_byte/in_last valid
//   in_last     in_byte is the final byte of the frame
//   in_ready    holding register empty (byte taken on in_valid & in_ready)
//   tx_enable   encoder enable, high for the whole frame
//   tx_data     current bit to the encoder, 0 whenever tx_enable is 0
//   busy        high from start-of-frame through the end of the gap
//   frame_done  one-clock pulse at normal frame end
//   underrun    one-clock pulse when a frame aborts for lack of a byte
module frame_tx #(
    parameter int ETU_CLKS = 8,
    parameter int GAP_ETUS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       tx_enable,
    output logic       tx_data,
    output logic       busy,
    output logic       frame_done,
    output logic       underrun
);

`ifdef FRAME_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, SOF, DATA, PAR, GAP} state_t;
`else
    typedef enum logic [2:0] {IDLE, SOF, DATA, GAP} state_t;
`endif

    localparam logic [7:0] ETU_LAST = 8'(ETU_CLKS - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_ETUS - 1);

    state_t      state_reg;
    logic [7:0]  etu_cnt_reg;
    logic [2:0]  bit_cnt_reg;
    logic [3:0]  gap_cnt_reg;
    logic [7:0]  shift_reg;
    logic        last_reg;
    logic [7:0]  hold_byte_reg;
    logic        hold_last_reg;
    logic        hold_full_reg;
`ifdef FRAME_TX_PARITY_EN
    logic        par_reg;
`endif

    logic etu_last;
    logic byte_end;
    logic gap_end;
    logic do_load;

    assign in_ready = !hold_full_reg;
    assign etu_last = (etu_cnt_reg == ETU_LAST);

    // Last clock of a byte's final ETU: this is where the holding register
    // is inspected to decide between continue, normal end, or underrun.
`ifdef FRAME_TX_PARITY_EN
    assign byte_end = (state_reg == PAR) && etu_last;
`else
    assign byte_end = (state_reg == DATA) && etu_last && (bit_cnt_reg == 3'd7);
`endif

    assign gap_end = (state_reg == GAP) && etu_last && (gap_cnt_reg == GAP_LAST);

    // Holding register moves into the shifter when a new frame starts
    // (from IDLE, or straight out of the gap) or a frame continues.
    // hold_full_reg is the pre-edge value, so a byte accepted on this same
    // edge is never seen by the decision.
    assign do_load = hold_full_reg &&
                     ((state_reg == IDLE) || gap_end || (byte_end && !last_reg));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            etu_cnt_reg   <= '0;
            bit_cnt_reg   <= '0;
            gap_cnt_reg   <= '0;
            shift_reg     <= '0;
            last_reg      <= 1'b0;
            hold_byte_reg <= '0;
            hold_last_reg <= 1'b0;
            hold_full_reg <= 1'b0;
`ifdef FRAME_TX_PARITY_EN
            par_reg       <= 1'b0;
`endif
            tx_enable     <= 1'b0;
            tx_data       <= 1'b0;
            busy          <= 1'b0;
            frame_done    <= 1'b0;
            underrun      <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;

            if (in_valid && !hold_full_reg) begin
                hold_byte_reg <= in_byte;
                hold_last_reg <= in_last;
                hold_full_reg <= 1'b1;
            end

            case (state_reg)
                IDLE: begin
                    if (hold_full_reg) begin
                        state_reg   <= SOF;
                        etu_cnt_reg <= '0;
                        tx_enable   <= 1'b1;
                        tx_data     <= 1'b1;
                        busy        <= 1'b1;
                    end
                end
                SOF: begin
                    if (etu_last) begin
                        etu_cnt_reg <= '0;
                        bit_cnt_reg <= '0;
                        state_reg   <= DATA;
                        tx_data     <= shift_reg[0];
                    end else begin
                        etu_cnt_reg <= etu_cnt_reg + 8'd1;
                    end
                end
                DATA: begin
                    if (etu_last) begin
                        etu_cnt_reg <= '0;
                        if (bit_cnt_reg == 3'd7) begin
`ifdef FRAME_TX_PARITY_EN
                            state_reg <= PAR;
                            tx_data   <= par_reg;
`endif
                        end else begin
                            bit_cnt_reg <= bit_cnt_reg + 3'd1;
                            shift_reg   <= shift_reg >> 1;
                            tx_data     <= shift_reg[1];
                        end
                    end else begin
                        etu_cnt_reg <= etu_cnt_reg + 8'd1;
                    end
                end
`ifdef FRAME_TX_PARITY_EN
                PAR: begin
                    if (etu_last) begin
                        etu_cnt_reg <= '0;
                    end else begin
                        etu_cnt_reg <= etu_cnt_reg + 8'd1;
                    end
                end
`endif
                GAP: begin
                    if (etu_last) begin
                        etu_cnt_reg <= '0;
                        if (gap_cnt_reg == GAP_LAST) begin
                            gap_cnt_reg <= '0;
                            // A byte already waiting starts the next frame
                            // without an extra idle clock.
                            if (hold_full_reg) begin
                                state_reg <= SOF;
                                tx_enable <= 1'b1;
                                tx_data   <= 1'b1;
                            end else begin
                                state_reg <= IDLE;
                                busy      <= 1'b0;
                            end
                        end else begin
                            gap_cnt_reg <= gap_cnt_reg + 4'd1;
                        end
                    end else begin
                        etu_cnt_reg <= etu_cnt_reg + 8'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase

            // Byte-end decision overrides whatever the case above chose.
            if (byte_end) begin
                etu_cnt_reg <= '0;
                bit_cnt_reg <= '0;
                gap_cnt_reg <= '0;
                if (!last_reg && hold_full_reg) begin
                    state_reg <= DATA;
                    tx_data   <= hold_byte_reg[0];
                end else begin
                    state_reg  <= GAP;
                    tx_enable  <= 1'b0;
                    tx_data    <= 1'b0;
                    frame_done <= last_reg;
                    underrun   <= !last_reg;
                end
            end

            if (do_load) begin
                shift_reg     <= hold_byte_reg;
                last_reg      <= hold_last_reg;
                hold_full_reg <= 1'b0;
`ifdef FRAME_TX_PARITY_EN
                par_reg       <= ~(^hold_byte_reg);
`endif
            end
        end
    end

endmodule

// File: tb/tb_frame_tx.sv
// tb_frame_tx -- self-checking bench for frame_tx.
// Outputs are logged once per clock (on the falling edge) and compared to
// a waveform built from the frame rules: a start ETU of 1, each byte's bits
// LSB first (plus an odd-parity ETU when FRAME_TX_PARITY_EN is defined),
// then a fixed gap carrying the end-of-frame pulse.
module tb_frame_tx;
    localparam int ETU = 8;
    localparam int GAP = 2;
`ifdef FRAME_TX_PARITY_EN
    localparam int BPB = 9;
`else
    localparam int BPB = 8;
`endif

    typedef logic [7:0] byte_q_t[$];

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] in_byte = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_ready, tx_enable, tx_data, busy, frame_done, underrun;

    frame_tx #(.ETU_CLKS(ETU), .GAP_ETUS(GAP)) dut (
        .clk(clk), .rst(rst), .in_byte(in_byte), .in_valid(in_valid),
        .in_last(in_last), .in_ready(in_ready), .tx_enable(tx_enable),
        .tx_data(tx_data), .busy(busy), .frame_done(frame_done),
        .underrun(underrun)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // pending offers: byte, last flag, earliest clock index to present it
    logic [7:0] pb[$];
    logic       pl[$];
    int         pe[$];
    // observed and expected {tx_enable, tx_data, frame_done, underrun, busy}
    logic [4:0] obs[$];
    logic [4:0] exq[];

    task automatic offer(input logic [7:0] b, input logic last, input int earliest);
        pb.push_back(b);
        pl.push_back(last);
        pe.push_back(earliest);
    endtask

    // Runs n clocks, logging outputs and presenting pending bytes in order.
    task automatic run(input int n);
        logic ready_seen;
        ready_seen = 1'b0;
        obs.delete();
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            obs.push_back({tx_enable, tx_data, frame_done, underrun, busy});
            if (in_valid && ready_seen) begin
                void'(pb.pop_front());
                void'(pl.pop_front());
                void'(pe.pop_front());
            end
            if (pb.size() > 0 && c >= pe[0]) begin
                in_valid = 1'b1;
                in_byte  = pb[0];
                in_last  = pl[0];
            end else begin
                in_valid = 1'b0;
                in_last  = 1'b0;
            end
            ready_seen = in_ready;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic put(input int k, input logic [4:0] v);
        if (k >= 0 && k < exq.size()) exq[k] = v;
    endtask

    // Writes one frame into the expected waveform starting at clock 'start'.
    task automatic put_frame(input int start, input byte_q_t bytes, input bit ur_end);
        int   k;
        logic bitv;
        k = start;
        for (int e = 0; e < ETU; e++) begin put(k, 5'b11001); k++; end
        foreach (bytes[b]) begin
            for (int i = 0; i < BPB; i++) begin
                if (i < 8) bitv = bytes[b][i];
                else       bitv = (($countones(bytes[b]) % 2) == 0);
                for (int e = 0; e < ETU; e++) begin put(k, {1'b1, bitv, 3'b001}); k++; end
            end
        end
        for (int g = 0; g < GAP * ETU; g++) begin
            put(k, {2'b00, (g == 0) && !ur_end, (g == 0) && ur_end, 1'b1});
            k++;
        end
    endtask

    function automatic string sig_name(input int s);
        case (s)
            0: return "tx_enable";
            1: return "tx_data";
            2: return "frame_done";
            3: return "underrun";
            default: return "busy";
        endcase
    endfunction

    task automatic compare_wave(input string name);
        int mism, first, en_obs, en_exp;
        for (int s = 0; s < 5; s++) begin
            mism = 0;
            first = -1;
            for (int i = 0; i < exq.size(); i++) begin
                if (obs[i][4-s] !== exq[i][4-s]) begin
                    mism++;
                    if (first < 0) first = i;
                end
            end
            total++;
            if (mism != 0) begin
                bad++;
                $display("FAIL %s.%s: %0d clocks differ, first at clock %0d got %b want %b",
                         name, sig_name(s), mism, first, obs[first][4-s], exq[first][4-s]);
            end
        end
        en_obs = 0;
        en_exp = 0;
        for (int i = 0; i < exq.size(); i++) begin
            if (obs[i][4] === 1'b1) en_obs++;
            if (exq[i][4] === 1'b1) en_exp++;
        end
        total++;
        if (en_obs != en_exp) begin
            bad++;
            $display("FAIL %s.enabled_clocks: got %0d want %0d", name, en_obs, en_exp);
        end
        $display("%s: compared %0d clocks", name, exq.size());
    endtask

    task automatic check_idle_outputs(input string name);
        logic [5:0] got;
        got = {in_ready, tx_enable, tx_data, busy, frame_done, underrun};
        total++;
        if (got !== 6'b100000) begin
            bad++;
            $display("FAIL %s: {in_ready,tx_enable,tx_data,busy,frame_done,underrun} got %b want 100000",
                     name, got);
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check_idle_outputs("reset_async");
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_held");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_released");
    endtask

    task automatic test_single_byte;
        byte_q_t q;
        int L;
        L = 5 + ETU * (1 + BPB) + GAP * ETU + 10;
        offer(8'h93, 1'b1, 3);
        run(L);
        exq = new[L];
        foreach (exq[i]) exq[i] = 5'b00000;
        q.push_back(8'h93);
        put_frame(5, q, 1'b0);
        compare_wave("single_0x93");
    endtask

    task automatic test_back_to_back;
        byte_q_t q;
        int L;
        L = 5 + ETU * (1 + 2 * BPB) + GAP * ETU + 10;
        offer(8'h26, 1'b0, 3);
        offer(8'h93, 1'b1, 3);
        run(L);
        exq = new[L];
        foreach (exq[i]) exq[i] = 5'b00000;
        q.push_back(8'h26);
        q.push_back(8'h93);
        put_frame(5, q, 1'b0);
        compare_wave("back_to_back_0x26_0x93");
    endtask

    task automatic test_underrun;
        byte_q_t q;
        int e, s2, L;
        e  = 5 + ETU * (1 + BPB);    // first clock after the first byte ends
        s2 = e + 20 + 2;             // second byte offered 20 clocks later
        L  = s2 + ETU * (1 + BPB) + GAP * ETU + 10;
        offer(8'hA5, 1'b0, 3);
        offer(8'h3C, 1'b1, e + 20);
        run(L);
        exq = new[L];
        foreach (exq[i]) exq[i] = 5'b00000;
        q.push_back(8'hA5);
        put_frame(5, q, 1'b1);
        q.delete();
        q.push_back(8'h3C);
        put_frame(s2, q, 1'b0);
        compare_wave("underrun");
    endtask

    // Several random frames offered with no pause: the gap between them
    // must be exactly GAP*ETU clocks.
    task automatic test_random_frames;
        byte_q_t fr[3];
        int starts[3];
        int nb, L;
        logic [7:0] b;
        starts[0] = 5;
        for (int f = 0; f < 3; f++) begin
            nb = $urandom_range(1, 3);
            for (int i = 0; i < nb; i++) begin
                b = 8'($urandom);
                fr[f].push_back(b);
                offer(b, (i == nb - 1), 3);
            end
            if (f < 2) starts[f+1] = starts[f] + ETU * (1 + BPB * nb) + GAP * ETU;
        end
        L = starts[2] + ETU * (1 + BPB * fr[2].size()) + GAP * ETU + 10;
        run(L);
        exq = new[L];
        foreach (exq[i]) exq[i] = 5'b00000;
        for (int f = 0; f < 3; f++) put_frame(starts[f], fr[f], 1'b0);
        compare_wave("random_continuous");
    endtask

    task automatic test_mid_reset;
        int pulses;
        @(negedge clk);
        in_byte = 8'h93; in_last = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0; in_last = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        total++;
        if (tx_enable !== 1'b1) begin
            bad++;
            $display("FAIL mid_reset_frame_active: tx_enable got %b want 1", tx_enable);
        end
        rst = 1'b1;
        #1;
        check_idle_outputs("mid_reset_async");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (frame_done || underrun || tx_enable) pulses++;
        end
        total++;
        if (pulses != 0) begin
            bad++;
            $display("FAIL mid_reset_discard: activity clocks got %0d want 0", pulses);
        end
        $display("mid_reset: checked 150 clocks after release");
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_underrun();
        test_random_frames();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/frame_tx.md
FRAME_TX -- requirements
Module: frame_tx

Interface
REQ-001 The module SHALL have parameter ETU_CLKS, default 8, giving clocks per ETU (bit period); legal range 2..255.
REQ-002 The module SHALL have parameter GAP_ETUS, default 2, giving the minimum idle ETUs after each frame; legal range 1..15.
REQ-003 clk  input  1  single clock, fc/16; all logic posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 in_byte  input  8  payload byte, sent LSB first.
REQ-006 in_valid  input  1  in_byte/in_last valid.
REQ-007 in_last  input  1  marks the final byte of the frame.
REQ-008 in_ready  output  1  holding register empty; byte accepted when in_valid & in_ready at posedge.
REQ-009 tx_enable  output  1  enable to the downstream Manchester encoder; high for the whole frame.
REQ-010 tx_data  output  1  current bit to the encoder, stable for ETU_CLKS clocks.
REQ-011 busy  output  1  high from SOF through end of gap.
REQ-012 frame_done  output  1  one-clock pulse at normal frame end.
REQ-013 underrun  output  1  one-clock pulse at frame abort due to missing byte.

Function
REQ-014 The block SHALL use states IDLE, SOF, DATA, PAR, GAP, driven by an ETU counter (0..ETU_CLKS-1) and a bit counter (0..7).
REQ-015 The block SHALL have a one-byte holding register plus a shift register; in_ready SHALL be high whenever the holding register is empty, including during DATA/PAR.
REQ-016 IDLE: when the holding register is full, next clock SHALL enter SOF and move the byte to the shift register; tx_enable=1 and tx_data=1 from that clock.
REQ-017 SOF SHALL last exactly ETU_CLKS clocks, then enter DATA with bit counter 0.
REQ-018 DATA: tx_data SHALL be shift[0]; each bit SHALL be held exactly ETU_CLKS clocks; after bit 7 the block SHALL enter PAR (macro on) or the byte-end decision (macro off).
REQ-019 PAR: tx_data SHALL be odd parity of the byte (XOR of the 8 bits, inverted), held ETU_CLKS clocks.
REQ-020 Byte-end decision: if the current byte had in_last=1, tx_enable SHALL drop and frame_done SHALL pulse on the next clock, entering GAP.
REQ-021 Byte-end, not last, holding register full: the next byte SHALL load and DATA restart with no idle clock (tx_enable stays high).
REQ-022 Byte-end, not last, holding register empty: tx_enable SHALL drop, underrun SHALL pulse, GAP entered; a later byte starts a new frame.
REQ-023 Enabled frame length SHALL be exactly ETU_CLKS*(1+9N) clocks (macro on) or ETU_CLKS*(1+8N) (macro off) for N bytes.
REQ-024 GAP: tx_enable=0, tx_data=0 for exactly GAP_ETUS*ETU_CLKS clocks, then IDLE; holding register may still accept one byte during GAP.
REQ-025 tx_data SHALL be 0 whenever tx_enable is 0.
REQ-026 A byte accepted on the same clock a byte-end decision reads the holding register SHALL NOT be used for that decision; it is evaluated at the next byte-end or IDLE.

Reset
REQ-027 rst SHALL immediately force IDLE, both counters 0, holding register empty, in_ready=1, tx_enable=0, tx_data=0, busy=0, frame_done=0, underrun=0.
REQ-028 Reset mid-frame SHALL discard the frame with no frame_done or underrun pulse.

Configuration
REQ-029 Macro FRAME_TX_PARITY_EN defined: PAR state present, 9 ETUs per byte; undefined: PAR state and parity logic SHALL be absent, 8 ETUs per byte.

Verification
REQ-030 Single byte 0x93, in_last=1, parity on, ETU_CLKS=8 -> tx_enable high 80 clocks; tx_data per ETU 1,1,1,0,0,1,0,0,1,1; frame_done at clock 81.
REQ-031 Bytes 0x26,0x93 back-to-back -> 152 enabled clocks; 0x26 bits 0,1,1,0,0,1,0,0 parity 0; no gap between bytes.
REQ-032 Two-byte frame, second byte presented 20 clocks after the first byte's parity ends -> underrun pulse at byte-end, tx_enable low, then 16-clock gap.
REQ-033 rst asserted at clock 30 of a frame -> all outputs 0 asynchronously, in_ready=1, no frame_done.
REQ-034 Macro undefined, byte 0x93 last -> 72 enabled clocks, no parity ETU.
REQ-035 Two single-byte frames offered continuously -> exactly 16 clocks tx_enable=0 between them.
